// File: rtl/store_lane_writer_if.sv
// Store port bundle: CPU-side request/response plus the 32-bit memory write channel.
// The slave modport is the writer's view; the master modport is the CPU/memory side.
interface store_lane_writer_if;
    logic        req;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic        err;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [3:0]  mem_be;
    logic        mem_ready;

    modport slave (
        input  req, size, addr, wdata, mem_ready,
        output stall, done, err, mem_valid, mem_addr, mem_data, mem_be
    );

    modport master (
        output req, size, addr, wdata, mem_ready,
        input  stall, done, err, mem_valid, mem_addr, mem_data, mem_be
    );
endinterface

// File: rtl/store_lane_writer.sv
// Store write unit: checks SB/SH/SW alignment, steers data onto byte lanes with
// byte enables, and runs a valid/ready write toward memory with a bounded wait.
module store_lane_writer #(
    parameter int TIMEOUT = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    store_lane_writer_if.slave   bus
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t      r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic        r_mem_valid, w_mem_valid_nxt;
    logic [31:0] r_mem_addr, w_mem_addr_nxt;
    logic [31:0] r_mem_data, w_mem_data_nxt;
    logic [3:0]  r_mem_be, w_mem_be_nxt;
    logic        r_done, w_done_nxt;
    logic        r_err, w_err_nxt;

    logic        w_legal;
    logic [3:0]  w_be;
    logic [31:0] w_data;

    always_comb begin
        w_legal = 1'b0;
        w_be    = 4'b0000;
        w_data  = bus.wdata;
        case (bus.size)
            2'b00: begin
                w_legal = 1'b1;
                w_be    = 4'b0001 << bus.addr[1:0];
                w_data  = {4{bus.wdata[7:0]}};
            end
            2'b01: begin
                w_legal = ~bus.addr[0];
                w_be    = bus.addr[1] ? 4'b1100 : 4'b0011;
                w_data  = {2{bus.wdata[15:0]}};
            end
            2'b10: begin
                w_legal = (bus.addr[1:0] == 2'b00);
                w_be    = 4'b1111;
                w_data  = bus.wdata;
            end
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_mem_valid_nxt = r_mem_valid;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_data_nxt  = r_mem_data;
        w_mem_be_nxt    = r_mem_be;
        w_done_nxt      = 1'b0;
        w_err_nxt       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req) begin
                    if (w_legal) begin
                        w_state_nxt     = S_BUSY;
                        w_mem_valid_nxt = 1'b1;
                        w_mem_addr_nxt  = {bus.addr[31:2], 2'b00};
                        w_mem_data_nxt  = w_data;
                        w_mem_be_nxt    = w_be;
                        w_cnt_nxt       = '0;
                    end else begin
                        w_state_nxt = S_RESP;
                        w_done_nxt  = 1'b1;
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                // Ready is tested first so an acceptance in the last wait cycle still succeeds.
                if (bus.mem_ready) begin
                    w_state_nxt     = S_RESP;
                    w_mem_valid_nxt = 1'b0;
                    w_mem_be_nxt    = 4'b0000;
                    w_done_nxt      = 1'b1;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_state_nxt     = S_RESP;
                    w_mem_valid_nxt = 1'b0;
                    w_mem_be_nxt    = 4'b0000;
                    w_done_nxt      = 1'b1;
                    w_err_nxt       = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            // REQ in RESP still belongs to the retiring store, so it is not sampled.
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_mem_be    <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_mem_valid <= w_mem_valid_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_data  <= w_mem_data_nxt;
            r_mem_be    <= w_mem_be_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign bus.stall     = ((r_state == S_IDLE) && bus.req) || (r_state == S_BUSY);
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.mem_valid = r_mem_valid;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_data  = r_mem_data;
    assign bus.mem_be    = r_mem_be;
endmodule

// File: tb/tb_store_lane_writer.sv
// Directed bench for store_lane_writer: lane steering, alignment errors,
// ready latency, timeout, back-to-back issue and asynchronous reset.
module tb_store_lane_writer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    store_lane_writer_if bus();

    store_lane_writer #(.TIMEOUT(16)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Entered and left 1 time unit after a rising edge with the unit idle.
    // rk: BUSY cycle in which MEM_READY first goes high (-1 = never).
    task automatic store(input string tag, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] d, input int rk, input logic [3:0] ebe,
                         input logic [31:0] edata, input logic eerr, input int edc,
                         input int evc);
        int cyc = 0;
        int vc  = 0;
        bit seen = 0;
        int dcyc = -1;
        bus.req = 1'b1; bus.size = sz; bus.addr = a; bus.wdata = d; bus.mem_ready = 1'b0;
        #1;
        chk({tag, "_stall0"}, 32'(bus.stall), 32'd1);
        while (!seen && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.mem_valid) begin
                chk({tag, "_be"},   32'(bus.mem_be), 32'(ebe));
                chk({tag, "_data"}, bus.mem_data, edata);
                chk({tag, "_addr"}, bus.mem_addr, {a[31:2], 2'b00});
                chk({tag, "_stallb"}, 32'(bus.stall), 32'd1);
                bus.mem_ready = (rk >= 0) && (vc >= rk);
                vc++;
            end else begin
                bus.mem_ready = 1'b0;
            end
            if (bus.done) begin
                seen = 1;
                dcyc = cyc;
                chk({tag, "_err"},    32'(bus.err), 32'(eerr));
                chk({tag, "_stallr"}, 32'(bus.stall), 32'd0);
                chk({tag, "_berel"},  32'(bus.mem_be), 32'd0);
                bus.req = 1'b0;
            end
        end
        chk({tag, "_doneseen"}, 32'(seen), 32'd1);
        chk({tag, "_donecyc"},  32'(dcyc), 32'(edc));
        chk({tag, "_vcycles"},  32'(vc), 32'(evc));
        bus.req = 1'b0; bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_donelo"},  32'(bus.done), 32'd0);
        chk({tag, "_stallid"}, 32'(bus.stall), 32'd0);
    endtask

    initial begin
        int bursts;
        int dones;
        int d2cyc;
        bit prev;
        bus.req = 1'b0; bus.size = 2'b00; bus.addr = '0; bus.wdata = '0; bus.mem_ready = 1'b0;

        #2 rst = 1'b1;
        #1;
        chk("rst_valid", 32'(bus.mem_valid), 32'd0);
        chk("rst_be",    32'(bus.mem_be), 32'd0);
        chk("rst_addr",  bus.mem_addr, 32'd0);
        chk("rst_data",  bus.mem_data, 32'd0);
        chk("rst_done",  32'(bus.done), 32'd0);
        chk("rst_err",   32'(bus.err), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        store("sb3", 2'b00, 32'h0000_1003, 32'h0000_00A5, 0, 4'b1000, 32'hA5A5_A5A5, 1'b0, 2, 1);
        store("sb0", 2'b00, 32'h0000_1000, 32'h0000_00A5, 0, 4'b0001, 32'hA5A5_A5A5, 1'b0, 2, 1);
        store("sb1", 2'b00, 32'h0000_1001, 32'h0000_00A5, 0, 4'b0010, 32'hA5A5_A5A5, 1'b0, 2, 1);
        store("sb2", 2'b00, 32'h0000_1002, 32'h0000_00A5, 0, 4'b0100, 32'hA5A5_A5A5, 1'b0, 2, 1);
        store("sh2", 2'b01, 32'h0000_2002, 32'h1234_BEEF, 0, 4'b1100, 32'hBEEF_BEEF, 1'b0, 2, 1);
        store("sh0", 2'b01, 32'h0000_2000, 32'h1234_BEEF, 0, 4'b0011, 32'hBEEF_BEEF, 1'b0, 2, 1);
        store("sh1", 2'b01, 32'h0000_2001, 32'h1234_BEEF, 0, 4'b0000, 32'h0,         1'b1, 1, 0);
        store("swr3", 2'b10, 32'h0000_3000, 32'hDEAD_BEEF, 3, 4'b1111, 32'hDEAD_BEEF, 1'b0, 5, 4);
        store("sw2",  2'b10, 32'h0000_3002, 32'hDEAD_BEEF, 0, 4'b0000, 32'h0,         1'b1, 1, 0);
        store("sz11", 2'b11, 32'h0000_3000, 32'hDEAD_BEEF, 0, 4'b0000, 32'h0,         1'b1, 1, 0);
        store("tmo",  2'b10, 32'h0000_3100, 32'h0BAD_F00D, -1, 4'b1111, 32'h0BAD_F00D, 1'b1, 17, 16);
        store("tmor", 2'b10, 32'h0000_3100, 32'h0BAD_F00D, 15, 4'b1111, 32'h0BAD_F00D, 1'b0, 17, 16);

        // Back-to-back: REQ held through both stores, dropped in the second RESP.
        bus.req = 1'b1; bus.size = 2'b10; bus.addr = 32'h0000_5000; bus.wdata = 32'hCAFE_F00D;
        bus.mem_ready = 1'b1;
        bursts = 0; dones = 0; d2cyc = -1; prev = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (bus.mem_valid && !prev) bursts++;
            prev = bus.mem_valid;
            if (bus.done) begin
                dones++;
                if (dones == 2) begin
                    d2cyc = c;
                    bus.req = 1'b0;
                end
            end
            @(posedge clk); #1;
        end
        bus.mem_ready = 1'b0;
        chk("b2b_bursts", 32'(bursts), 32'd2);
        chk("b2b_dones",  32'(dones), 32'd2);
        chk("b2b_d2cyc",  32'(d2cyc), 32'd5);

        // Asynchronous reset in the middle of a BUSY wait.
        bus.req = 1'b1; bus.size = 2'b10; bus.addr = 32'h0000_4000; bus.wdata = 32'h1111_2222;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_valid", 32'(bus.mem_valid), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.mem_valid), 32'd0);
        chk("arst_be",    32'(bus.mem_be), 32'd0);
        chk("arst_done",  32'(bus.done), 32'd0);
        chk("arst_err",   32'(bus.err), 32'd0);
        bus.req = 1'b0;
        #1;
        chk("arst_stall", 32'(bus.stall), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_valid", 32'(bus.mem_valid), 32'd0);
        chk("post_done",  32'(bus.done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
